mii_rx_deframer: RTL and testbench

Receive-side deframer for the 64-bit 1.6T MII stream: it consumes the `o_tx_data`/`o_tx_ctrl` word stream produced by the MII frame generator and recovers frames. It strips the start word, delivers payload as an 8-byte beat stream with `last`/`keep`/`err` qualifiers, and keeps frame, error and length statistics. It sits after the MII link, in place of (or beside) the generator checker, and feeds the MAC receive path.

---
 rtl/mii_pkg.sv | 24 ++
 rtl/mii_rx_deframer.sv | 143 ++++++++++++++
 tb/tb_mii_rx_deframer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mii_pkg.sv
// Encoding shared by the MII generator, checker and receive deframer:
// control codes, preamble/SFD bytes, deframer states and the term-length keep mask.
package mii_pkg;

   localparam logic [7:0] CODE_IDLE  = 8'h07;
   localparam logic [7:0] CODE_START = 8'hFB;
   localparam logic [7:0] CODE_TERM  = 8'hFD;
   localparam logic [7:0] CODE_ERROR = 8'hFE;
   localparam logic [7:0] PREAMBLE   = 8'h55;
   localparam logic [7:0] SFD        = 8'hD5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DATA = 1'b1
   } state_e;

   // n valid bytes (1..8) -> low-aligned byte mask; n = 8 yields 0xFF.
   function automatic logic [7:0] keep_from_n(input logic [7:0] n);
      logic [8:0] ones;
      ones = (9'd1 << n[3:0]) - 9'd1;
      return ones[7:0];
   endfunction

endpackage

// File: rtl/mii_rx_deframer.sv
// Recovers frames from the 64-bit MII word stream: strips START, delays payload by one
// word so the TERM length can qualify the final beat, and keeps frame/error statistics.
module mii_rx_deframer
   import mii_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int MAX_WORDS  = 190,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    i_rst,
   input  logic [DATA_WIDTH-1:0]   i_rx_data,
   input  logic                    i_rx_ctrl,
   output logic [DATA_WIDTH-1:0]   o_data,
   output logic                    o_valid,
   output logic                    o_last,
   output logic [DATA_WIDTH/8-1:0] o_keep,
   output logic                    o_err,
   output logic [CNT_WIDTH-1:0]    o_frame_cnt,
   output logic [CNT_WIDTH-1:0]    o_err_cnt,
   output logic [CNT_WIDTH-1:0]    o_last_len
);

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   hold_q, hold_d;
   logic                    hold_v_q, hold_v_d;
   logic [CNT_WIDTH-1:0]    wcnt_q, wcnt_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    last_q, last_d;
   logic [DATA_WIDTH/8-1:0] keep_q, keep_d;
   logic                    err_q, err_d;
   logic [CNT_WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
   logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
   logic [CNT_WIDTH-1:0]    last_len_q, last_len_d;

   logic [7:0] code;
   logic [7:0] term_n;
   logic       start_ok;
   logic       term_ok;

   assign code     = i_rx_data[7:0];
   assign term_n   = i_rx_data[15:8];
   assign start_ok = (i_rx_data[55:8] == {6{PREAMBLE}}) && (i_rx_data[63:56] == SFD);
   assign term_ok  = (code == CODE_TERM) && (term_n >= 8'd1) && (term_n <= 8'd8) && hold_v_q;

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_v_d    = hold_v_q;
      wcnt_d      = wcnt_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      last_d      = 1'b0;
      keep_d      = '0;
      err_d       = 1'b0;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      last_len_d  = last_len_q;

      if (state_q == ST_IDLE) begin
         if (i_rx_ctrl && (code == CODE_START)) begin
            if (start_ok) begin
               state_d  = ST_DATA;
               hold_v_d = 1'b0;
               wcnt_d   = '0;
            end else if (err_cnt_q != '1) begin
               err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            end
         end
      end else if (!i_rx_ctrl && (wcnt_q != CNT_WIDTH'(MAX_WORDS))) begin
         if (hold_v_q) begin
            data_d  = hold_q;
            valid_d = 1'b1;
            keep_d  = '1;
         end
         hold_d   = i_rx_data;
         hold_v_d = 1'b1;
         wcnt_d   = wcnt_q + CNT_WIDTH'(1);
      end else if (i_rx_ctrl && term_ok) begin
         data_d     = hold_q;
         valid_d    = 1'b1;
         last_d     = 1'b1;
         keep_d     = keep_from_n(term_n);
         last_len_d = ((wcnt_q - CNT_WIDTH'(1)) << 3) + CNT_WIDTH'(term_n);
         if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
         state_d    = ST_IDLE;
         hold_v_d   = 1'b0;
      end else begin
         // Abort: overlong frame or any control word other than a well-formed TERM.
         if (hold_v_q) begin
            data_d  = hold_q;
            valid_d = 1'b1;
            last_d  = 1'b1;
            keep_d  = '1;
            err_d   = 1'b1;
         end
         if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
         state_d  = ST_IDLE;
         hold_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!i_rst) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         hold_v_q    <= 1'b0;
         wcnt_q      <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         keep_q      <= '0;
         err_q       <= 1'b0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
         last_len_q  <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_v_q    <= hold_v_d;
         wcnt_q      <= wcnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         keep_q      <= keep_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
         last_len_q  <= last_len_d;
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_last      = last_q;
   assign o_keep      = keep_q;
   assign o_err       = err_q;
   assign o_frame_cnt = frame_cnt_q;
   assign o_err_cnt   = err_cnt_q;
   assign o_last_len  = last_len_q;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Randomized bench: frames are described at frame level and the expected beat stream
// and statistics are derived from frame length, term count and abort position.
module tb_mii_rx_deframer;

   localparam int MAXW = 190;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] rx_data = 64'h0707070707070707;
   logic        rx_ctrl = 1'b1;
   logic [63:0] o_data;
   logic        o_valid;
   logic        o_last;
   logic [7:0]  o_keep;
   logic        o_err;
   logic [15:0] o_frame_cnt;
   logic [15:0] o_err_cnt;
   logic [15:0] o_last_len;

   mii_rx_deframer #(.DATA_WIDTH(64), .MAX_WORDS(MAXW), .CNT_WIDTH(16)) dut (
      .clk         (clk),
      .i_rst       (rst_n),
      .i_rx_data   (rx_data),
      .i_rx_ctrl   (rx_ctrl),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_last      (o_last),
      .o_keep      (o_keep),
      .o_err       (o_err),
      .o_frame_cnt (o_frame_cnt),
      .o_err_cnt   (o_err_cnt),
      .o_last_len  (o_last_len)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        e;
      logic [15:0] len;
      logic [15:0] fc;
   } beat_t;

   beat_t       exp_q[$];
   int          nvec = 0;
   int          nmis = 0;
   logic [15:0] m_frame = 0;
   logic [15:0] m_err = 0;
   logic [15:0] m_len = 0;

   localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
   localparam logic [63:0] START_W = 64'hD5555555555555FB;
   localparam logic [63:0] BADSFD  = 64'hD4555555555555FB;

   // Scoreboard: every beat must match the next expected beat in order.
   always @(negedge clk) begin
      if (o_valid) begin
         nvec++;
         if (exp_q.size() == 0) begin
            nmis++;
            $display("FAIL unexpected_beat: got data=%h keep=%h last=%b err=%b, expected no beat",
                     o_data, o_keep, o_last, o_err);
         end else begin
            beat_t b;
            b = exp_q.pop_front();
            if (o_data !== b.d || o_keep !== b.k || o_last !== b.l || (b.l && o_err !== b.e)) begin
               nmis++;
               $display("FAIL beat: got data=%h keep=%h last=%b err=%b, expected data=%h keep=%h last=%b err=%b",
                        o_data, o_keep, o_last, o_err, b.d, b.k, b.l, b.e);
            end
            if (b.l && !b.e) begin
               nvec++;
               if (o_last_len !== b.len || o_frame_cnt !== b.fc) begin
                  nmis++;
                  $display("FAIL last_stats: got len=%0d frames=%0d, expected len=%0d frames=%0d",
                           o_last_len, o_frame_cnt, b.len, b.fc);
               end
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [15:0] sat(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic send(input logic c, input logic [63:0] d);
      @(negedge clk);
      rx_ctrl = c;
      rx_data = d;
   endtask

   task automatic send_idle(input int n);
      repeat (n) send(1'b1, IDLE_W);
   endtask

   task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l,
                       input logic e, input logic [15:0] len, input logic [15:0] fc);
      beat_t b;
      b.d = d; b.k = k; b.l = l; b.e = e; b.len = len; b.fc = fc;
      exp_q.push_back(b);
   endtask

   function automatic logic [63:0] term_word(input logic [7:0] n);
      logic [63:0] w;
      w = rnd64();
      w[7:0]  = 8'hFD;
      w[15:8] = n;
      return w;
   endfunction

   // Good frame of k payload words; final word carries n valid bytes.
   task automatic send_good_frame(input int k, input int n);
      logic [63:0] w;
      send(1'b1, START_W);
      for (int i = 0; i < k; i++) begin
         w = rnd64();
         send(1'b0, w);
         if (i < k - 1) push(w, 8'hFF, 1'b0, 1'b0, 16'd0, 16'd0);
      end
      m_frame = sat(m_frame);
      m_len   = 16'((k - 1) * 8 + n);
      push(w, 8'hFF >> (8 - n), 1'b1, 1'b0, m_len, m_frame);
      send(1'b1, term_word(8'(n)));
   endtask

   // k payload words then a killing word: 0 ERROR, 1 IDLE, 2 START, 3 TERM bad n,
   // 4 unknown code, 5 extra data word, 6 well-formed TERM (aborts only with k == 0).
   task automatic send_abort_frame(input int k, input int kind);
      logic [63:0] w;
      logic [63:0] kill;
      send(1'b1, START_W);
      for (int i = 0; i < k; i++) begin
         w = rnd64();
         send(1'b0, w);
         if (i < k - 1) push(w, 8'hFF, 1'b0, 1'b0, 16'd0, 16'd0);
      end
      if (k > 0) push(w, 8'hFF, 1'b1, 1'b1, 16'd0, 16'd0);
      m_err = sat(m_err);
      case (kind)
         0: kill = {rnd64() & 64'hFFFF_FFFF_FFFF_FF00} | 64'hFE;
         1: kill = IDLE_W;
         2: kill = START_W;
         3: kill = term_word(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(9, 255)));
         4: kill = {rnd64() & 64'hFFFF_FFFF_FFFF_FF00} | 64'h9C;
         6: kill = term_word(8'($urandom_range(1, 8)));
         default: kill = rnd64();
      endcase
      send((kind == 5) ? 1'b0 : 1'b1, kill);
   endtask

   task automatic check_end(input string name);
      send_idle(3);
      nvec++;
      if (exp_q.size() != 0) begin
         nmis++;
         $display("FAIL %s_missing_beats: got %0d beats outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
      nvec++;
      if (o_frame_cnt !== m_frame || o_err_cnt !== m_err || o_last_len !== m_len) begin
         nmis++;
         $display("FAIL %s_counters: got frames=%0d errs=%0d len=%0d, expected frames=%0d errs=%0d len=%0d",
                  name, o_frame_cnt, o_err_cnt, o_last_len, m_frame, m_err, m_len);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) send(1'b0, rnd64());
      nvec++;
      if (o_valid !== 1'b0 || o_last !== 1'b0 || o_err !== 1'b0 || o_keep !== 8'h00 || o_data !== 64'h0) begin
         nmis++;
         $display("FAIL reset_outputs: got valid=%b last=%b err=%b keep=%h data=%h, expected all 0",
                  o_valid, o_last, o_err, o_keep, o_data);
      end
      nvec++;
      if (o_frame_cnt !== 16'd0 || o_err_cnt !== 16'd0 || o_last_len !== 16'd0) begin
         nmis++;
         $display("FAIL reset_counters: got %0d %0d %0d, expected 0 0 0", o_frame_cnt, o_err_cnt, o_last_len);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send(1'b1, IDLE_W);
         nvec++;
         if (o_valid !== 1'b0) begin
            nmis++;
            $display("FAIL idle_valid: got valid=%b, expected 0", o_valid);
         end
      end
      check_end("reset");
   endtask

   task automatic test_basic_frame();
      send_good_frame(3, 3);
      check_end("basic");
      nvec++;
      if (o_last_len !== 16'd19 || o_frame_cnt !== 16'd1) begin
         nmis++;
         $display("FAIL basic_len: got len=%0d frames=%0d, expected len=19 frames=1", o_last_len, o_frame_cnt);
      end
   endtask

   task automatic test_back_to_back();
      send_good_frame(1, 8);
      send_good_frame($urandom_range(1, 6), $urandom_range(1, 8));
      check_end("back_to_back");
      nvec++;
      if (o_frame_cnt !== 16'd3) begin
         nmis++;
         $display("FAIL b2b_frames: got %0d, expected 3", o_frame_cnt);
      end
   endtask

   task automatic test_error_abort();
      send_abort_frame(3, 0);
      for (int i = 0; i < 4; i++) send(1'b0, rnd64());
      send(1'b1, term_word(8'd4));
      check_end("error_abort");
      nvec++;
      if (o_err_cnt !== 16'd1) begin
         nmis++;
         $display("FAIL abort_errcnt: got %0d, expected 1", o_err_cnt);
      end
   endtask

   task automatic test_bad_start();
      send(1'b1, BADSFD);
      m_err = sat(m_err);
      send(1'b0, rnd64());
      send(1'b0, rnd64());
      send(1'b1, term_word(8'd2));
      check_end("bad_sfd");
      send_abort_frame(0, 6);
      check_end("start_term");
      for (int kind = 0; kind <= 4; kind++) begin
         send_abort_frame($urandom_range(0, 3), kind);
         check_end("abort_kind");
      end
   endtask

   task automatic test_max_words();
      send_abort_frame(MAXW, 5);
      send(1'b0, rnd64());
      check_end("max_abort");
      send_good_frame(MAXW, $urandom_range(1, 8));
      check_end("max_good");
   endtask

   task automatic test_random();
      for (int f = 0; f < 30; f++) begin
         if ($urandom_range(0, 2) != 0)
            send_good_frame($urandom_range(1, 12), $urandom_range(1, 8));
         else
            send_abort_frame($urandom_range(0, 8), $urandom_range(0, 4));
         if ($urandom_range(0, 1) == 1) send_idle($urandom_range(1, 3));
      end
      check_end("random");
   endtask

   task automatic test_reset_midframe();
      logic [63:0] w[4];
      send(1'b1, START_W);
      for (int i = 0; i < 4; i++) begin
         w[i] = rnd64();
         send(1'b0, w[i]);
         if (i < 3) push(w[i], 8'hFF, 1'b0, 1'b0, 16'd0, 16'd0);
      end
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(1'b1, term_word(8'd5));
         nvec++;
         if (o_last !== 1'b0 || o_valid !== 1'b0) begin
            nmis++;
            $display("FAIL midreset_beat: got valid=%b last=%b, expected 0 0", o_valid, o_last);
         end
      end
      rst_n = 1'b1;
      m_frame = 0;
      m_err   = 0;
      m_len   = 0;
      check_end("midreset");
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_back_to_back();
      test_error_abort();
      test_bad_start();
      test_max_words();
      test_random();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
